// File: rtl/vx_execute_lane_serializer_pkg.sv
// Shared types for the execute lane serializer.
// Header layout, FSM states and the beat-index width helper.
package VX_gpu_pkg;

  typedef struct packed {
    logic [47:0] uuid;
    logic [7:0]  wid;
    logic [31:0] pc;
    logic [7:0]  op_type;
    logic [15:0] op_args;
    logic        wb;
    logic [4:0]  rd;
    logic [9:0]  tid;
  } exec_hdr_t;

  localparam int EXEC_HDR_W = $bits(exec_hdr_t);

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_execute_lane_serializer_group_find_next.sv
// Priority search for the lowest set mask bit above cur.
// Ports: mask, cur in; next, found, is_last out.
module vx_group_find_next #(
  parameter int NUM_GROUPS = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_GROUPS-1:0] mask,
  input  logic [IDX_W-1:0]      cur,
  output logic [IDX_W-1:0]      next,
  output logic                  found,
  output logic                  is_last
);

  // Descending scan so the lowest qualifying group wins.
  always_comb begin
    next  = '0;
    found = 1'b0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (mask[g] && (g > int'(cur))) begin
        next  = IDX_W'(g);
        found = 1'b1;
      end
    end
  end

  assign is_last = !found;

endmodule

// File: rtl/vx_execute_lane_serializer.sv
// Splits a full-warp execute packet into lane-group beats.
// Ports: in_* packet (valid/ready), out_* beats with pid/sop/eop.
module vx_execute_lane_serializer
  import VX_gpu_pkg::*;
#(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int HDR_W       = EXEC_HDR_W,
  parameter int SKIP_EMPTY  = 1,
  parameter int PID_WIDTH   = log2up(NUM_THREADS / NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [HDR_W-1:0]            in_hdr,
  input  logic                        in_is_vec,
  input  logic [NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [HDR_W-1:0]            out_hdr,
  output logic                        out_is_vec,
  output logic [NUM_LANES-1:0]        out_tmask,
  output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs3_data,
  output logic [PID_WIDTH-1:0]        out_pid,
  output logic                        out_sop,
  output logic                        out_eop
);

  localparam int P  = NUM_THREADS / NUM_LANES;
  localparam int DW = NUM_LANES * XLEN;

  ser_state_e state_q, state_d;

  logic [P-1:0]           grp_mask;
  logic [P-1:0]           emit_mask;
  logic [P-1:0]           mask_q;
  logic [PID_WIDTH-1:0]   pid_q;
  logic [PID_WIDTH-1:0]   first_pid;
  logic [PID_WIDTH-1:0]   next_pid;
  logic                   found;
  logic                   is_last;
  logic                   sop_q;
  logic                   is_vec_q;
  logic                   load;
  logic                   adv;
  logic [HDR_W-1:0]       hdr_q;
  logic [NUM_THREADS-1:0] tmask_q;
  logic [NUM_THREADS*XLEN-1:0] rs1_q;
  logic [NUM_THREADS*XLEN-1:0] rs2_q;
  logic [NUM_THREADS*XLEN-1:0] rs3_q;

  // An all-empty scalar packet still emits group 0 so the
  // instruction is visible downstream.
  always_comb begin
    grp_mask = '0;
    for (int g = 0; g < P; g++) begin
      grp_mask[g] = |in_tmask[g*NUM_LANES +: NUM_LANES];
    end
    if (in_is_vec || (SKIP_EMPTY == 0)) begin
      emit_mask = '1;
    end else if (grp_mask == '0) begin
      emit_mask = P'(1);
    end else begin
      emit_mask = grp_mask;
    end
    first_pid = '0;
    for (int g = P - 1; g >= 0; g--) begin
      if (emit_mask[g]) begin
        first_pid = PID_WIDTH'(g);
      end
    end
  end

  vx_group_find_next #(
    .NUM_GROUPS (P),
    .IDX_W      (PID_WIDTH)
  ) u_find (
    .mask    (mask_q),
    .cur     (pid_q),
    .next    (next_pid),
    .found   (found),
    .is_last (is_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (is_last) begin
            in_ready = 1'b1;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q   <= '0;
      pid_q    <= '0;
      sop_q    <= 1'b0;
      is_vec_q <= 1'b0;
      hdr_q    <= '0;
      tmask_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
    end else if (load) begin
      mask_q   <= emit_mask;
      pid_q    <= first_pid;
      sop_q    <= 1'b1;
      is_vec_q <= in_is_vec;
      hdr_q    <= in_hdr;
      tmask_q  <= in_tmask;
      rs1_q    <= in_rs1_data;
      rs2_q    <= in_rs2_data;
      rs3_q    <= in_rs3_data;
    end else if (adv && found) begin
      pid_q <= next_pid;
      sop_q <= 1'b0;
    end
  end

  always_comb begin
    int b;
    b            = int'(pid_q);
    out_tmask    = tmask_q[b*NUM_LANES +: NUM_LANES];
    out_rs1_data = rs1_q[b*DW +: DW];
    out_rs2_data = rs2_q[b*DW +: DW];
    out_rs3_data = rs3_q[b*DW +: DW];
  end

  assign out_hdr    = hdr_q;
  assign out_is_vec = is_vec_q;
  assign out_pid    = pid_q;
  assign out_sop    = out_valid & sop_q;
  assign out_eop    = out_valid & is_last;

endmodule

// File: doc/vx_execute_lane_serializer.md
Name: vx_execute_lane_serializer

Overview:
- Accepts one full-width execute packet (NUM_THREADS lanes) and emits it as a sequence of NUM_LANES-wide beats tagged with pid/sop/eop.
- Sits between the dispatch stage and any functional unit narrower than the warp.
- Generalises the fixed-width execute bundle:
  - parametrised lane split;
  - optional skipping of lane groups whose thread mask is empty;
  - vector-mode override that never skips.

Parameters:
- NUM_THREADS, 8, lanes in the input packet (power of 2).
- NUM_LANES, 2, lanes per output beat (power of 2, divides NUM_THREADS).
- XLEN, 32, operand width.
- HDR_W, 128, width of the packed pass-through header (uuid, wid, PC, op_type, op_args, wb, rd, tid).
- SKIP_EMPTY, 1, 1 = skip lane groups with zero tmask in scalar mode.
- PID_WIDTH, LOG2UP(NUM_THREADS/NUM_LANES), derived; beat index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  input packet valid
- in_ready  out  1  input packet accepted
- in_hdr  in  HDR_W  pass-through header
- in_is_vec  in  1  vector instruction; disables skipping
- in_tmask  in  NUM_THREADS  thread mask
- in_rs1_data  in  NUM_THREADS*XLEN  operand 1
- in_rs2_data  in  NUM_THREADS*XLEN  operand 2
- in_rs3_data  in  NUM_THREADS*XLEN  operand 3
- out_valid  out  1  beat valid
- out_ready  in  1  beat accepted
- out_hdr  out  HDR_W  latched header, constant across beats
- out_is_vec  out  1  latched is_vec
- out_tmask  out  NUM_LANES  tmask slice for current pid
- out_rs1_data  out  NUM_LANES*XLEN  operand 1 slice
- out_rs2_data  out  NUM_LANES*XLEN  operand 2 slice
- out_rs3_data  out  NUM_LANES*XLEN  operand 3 slice
- out_pid  out  PID_WIDTH  lane-group index
- out_sop  out  1  first beat of packet
- out_eop  out  1  last beat of packet

Behaviour:
- Reset (async assert, sync deassert in caller): state IDLE, out_valid=0, out_pid=0, out_sop=0, out_eop=0, all data registers 0. Reset mid-packet discards the packet with no further beats.
- States:
  - IDLE: in_ready=1. On in_valid, latch all inputs, compute group mask G[g] = |in_tmask[g*NUM_LANES +: NUM_LANES]; set pid = first emitted group; go SEND.
  - SEND: out_valid=1.
    - out_ready=1 and !out_eop: pid jumps to next emitted group.
    - out_ready=1 and out_eop: go IDLE, or reload directly if in_valid.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_eop). Back-to-back packets have no bubble.
- Emitted-group set:
  - if in_is_vec or SKIP_EMPTY=0, all groups 0..P-1, where P = NUM_THREADS/NUM_LANES;
  - else groups with G[g]=1;
  - if tmask is all zero in scalar skip mode, exactly one beat with pid 0 and tmask 0, so downstream still sees the instruction.
- Derived beat flags:
  - out_sop=1 only on the first emitted beat;
  - out_eop=1 when no emitted group exists above pid;
  - a single-beat packet has sop=eop=1.
- Latency: input accepted at cycle N, first beat valid at N+1. Throughput is one beat per cycle while out_ready=1.
- out_valid, once high, stays high and all out_* stay stable until out_ready (AXI-style).
- Next-group search is a priority encoder over G masked above pid, completed in one cycle with no extra latency.
- P=1 (NUM_LANES=NUM_THREADS) degenerates to a 1-deep register slice: pid always 0, sop=eop=1.

Decomposition:
- Shared package VX_gpu_pkg holds:
  - the header struct (exec_hdr_t) used to pack in_hdr/out_hdr;
  - the PID_WIDTH helper.
- One sub-module, vx_group_find_next: NUM_GROUPS-bit mask plus current index in; next index, found, and is_last out.

Test Plan:
- NUM_THREADS=8, NUM_LANES=2, tmask=8'hFF, scalar, out_ready=1 -> 4 beats on consecutive cycles, pid 0,1,2,3, sop on pid0, eop on pid3, each tmask 2'b11.
- tmask=8'b0011_0000, scalar, SKIP_EMPTY=1 -> single beat pid=2, tmask=2'b11, sop=eop=1.
- Same tmask with in_is_vec=1 -> 4 beats pid 0..3, tmask 00,00,11,00; out_is_vec=1 on every beat.
- tmask=8'h00, scalar -> one beat pid 0, tmask 0, sop=eop=1.
- Two packets back-to-back with in_valid held high, out_ready toggling 1,0,1,… -> no beat lost or duplicated, data held stable while stalled, second packet's first beat follows the first packet's eop with no idle cycle, in_ready pulses only on eop acceptance.
- Assert reset low during beat pid=1 of 4 -> out_valid=0 immediately (async), in_ready=1 after release, no further beats of the aborted packet.
